// File: rtl/lbm_pkg.sv
// Shared constants for the lattice-Boltzmann datapath: D2Q9 population count,
// default datapath width, and the level-count helper for the reduction tree.
package lbm_pkg;

  localparam int Q = 9;
  localparam int DEFAULT_DATA_WIDTH = 32;

  // Never returns 0, so a 2-input (or degenerate) tree still has one registered level.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/adder_tree_pipe_if.sv
// Valid/ready bundle around the reduction tree: operand push side and sum pop side.
interface adder_tree_pipe_if
  import lbm_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_INPUTS = Q
);

  logic [NUM_INPUTS*DATA_WIDTH-1:0] Din;
  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WIDTH-1:0]            Dout;
  logic                             out_valid;
  logic                             out_ready;
  logic                             ovf;

  modport master (
    output Din, in_valid, out_ready,
    input  in_ready, Dout, out_valid, ovf
  );

  modport slave (
    input  Din, in_valid, out_ready,
    output in_ready, Dout, out_valid, ovf
  );

endinterface

// File: rtl/adder_tree_pipe_level.sv
// One registered level of the reduction tree: pairwise signed adds, an odd
// trailing operand passes through sign-extended, all gated by the global advance.
module adder_tree_level
  import lbm_pkg::*;
#(
  parameter int IN_COUNT = 2,
  parameter int IN_WIDTH = 32,
  localparam int OUT_COUNT = (IN_COUNT + 1) / 2,
  localparam int OUT_WIDTH = IN_WIDTH + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           adv,
  input  logic                           in_valid,
  input  logic [IN_COUNT*IN_WIDTH-1:0]   din,
  output logic                           out_valid,
  output logic [OUT_COUNT*OUT_WIDTH-1:0] dout
);

  logic [OUT_COUNT*OUT_WIDTH-1:0] sum_c;

  for (genvar i = 0; i < OUT_COUNT; i++) begin : g_lane
    logic [IN_WIDTH-1:0] a;
    assign a = din[2*i*IN_WIDTH +: IN_WIDTH];
    if (2*i + 1 < IN_COUNT) begin : g_add
      logic [IN_WIDTH-1:0] b;
      assign b = din[(2*i+1)*IN_WIDTH +: IN_WIDTH];
      assign sum_c[i*OUT_WIDTH +: OUT_WIDTH] = {a[IN_WIDTH-1], a} + {b[IN_WIDTH-1], b};
    end else begin : g_pass
      assign sum_c[i*OUT_WIDTH +: OUT_WIDTH] = {a[IN_WIDTH-1], a};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
    end else if (adv) begin
      out_valid <= in_valid;
      dout      <= sum_c;
    end
  end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined N-input signed reduction adder (one sum per clock, LEVELS cycles latency).
// Define ADDER_TREE_PIPE_SAT_EN to clamp Dout on overflow instead of wrapping.
module adder_tree_pipe
  import lbm_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_INPUTS = Q,
  localparam int LEVELS    = clog2_min1(NUM_INPUTS)
) (
  input logic              clk,
  input logic              rst_n,
  adder_tree_pipe_if.slave bus
);

  localparam int FW = DATA_WIDTH + LEVELS;

  logic          adv;
  logic          valid_f;
  logic [FW-1:0] sum_f;
  logic [LEVELS:0] top_bits;
  logic          ovf_raw;

  // Level k carries ceil(N/2^k) operands of DATA_WIDTH+k bits.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int L_IN_COUNT  = (NUM_INPUTS + (1 << k) - 1) >> k;
    localparam int L_IN_W      = DATA_WIDTH + k;
    localparam int L_OUT_COUNT = (L_IN_COUNT + 1) / 2;
    localparam int L_OUT_W     = L_IN_W + 1;

    logic [L_IN_COUNT*L_IN_W-1:0]   din;
    logic                           vin;
    logic [L_OUT_COUNT*L_OUT_W-1:0] dout;
    logic                           vout;

    if (k == 0) begin : g_first
      assign din = bus.Din;
      assign vin = bus.in_valid && adv;
    end else begin : g_next
      assign din = g_lvl[k-1].dout;
      assign vin = g_lvl[k-1].vout;
    end

    adder_tree_level #(
      .IN_COUNT (L_IN_COUNT),
      .IN_WIDTH (L_IN_W)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (adv),
      .in_valid  (vin),
      .din       (din),
      .out_valid (vout),
      .dout      (dout)
    );
  end

  assign sum_f   = g_lvl[LEVELS-1].dout;
  assign valid_f = g_lvl[LEVELS-1].vout;

  assign adv          = !valid_f || bus.out_ready;
  assign bus.in_ready = adv;

  // The exact sum fits DATA_WIDTH only if every bit above the target sign bit matches it.
  assign top_bits = sum_f[FW-1:DATA_WIDTH-1];
  assign ovf_raw  = !((&top_bits) || !(|top_bits));

  assign bus.out_valid = valid_f;
  assign bus.ovf       = valid_f && ovf_raw;

`ifdef ADDER_TREE_PIPE_SAT_EN
  assign bus.Dout = !ovf_raw     ? sum_f[DATA_WIDTH-1:0] :
                    sum_f[FW-1]  ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                   {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
  assign bus.Dout = sum_f[DATA_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed/self-checking bench for adder_tree_pipe: 9x32 main instance plus
// 2/8/17-input 16-bit instances for the latency and width sweep.
module tb_adder_tree_pipe;
  import lbm_pkg::*;

  typedef struct packed { logic [31:0] d; logic o; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passes = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  adder_tree_pipe_if #(.DATA_WIDTH(32), .NUM_INPUTS(9))  m   ();
  adder_tree_pipe_if #(.DATA_WIDTH(16), .NUM_INPUTS(2))  s2  ();
  adder_tree_pipe_if #(.DATA_WIDTH(16), .NUM_INPUTS(8))  s8  ();
  adder_tree_pipe_if #(.DATA_WIDTH(16), .NUM_INPUTS(17)) s17 ();

  adder_tree_pipe #(.DATA_WIDTH(32), .NUM_INPUTS(9))  u_dut (.clk(clk), .rst_n(rst_n), .bus(m));
  adder_tree_pipe #(.DATA_WIDTH(16), .NUM_INPUTS(2))  u_n2  (.clk(clk), .rst_n(rst_n), .bus(s2));
  adder_tree_pipe #(.DATA_WIDTH(16), .NUM_INPUTS(8))  u_n8  (.clk(clk), .rst_n(rst_n), .bus(s8));
  adder_tree_pipe #(.DATA_WIDTH(16), .NUM_INPUTS(17)) u_n17 (.clk(clk), .rst_n(rst_n), .bus(s17));

  function automatic exp_t model(input longint s, input int dw);
    exp_t e;
    longint mx, mn;
    logic [63:0] u;
    mx = (longint'(1) << (dw - 1)) - 1;
    mn = -mx - 1;
    u = s;
    e.o = (s > mx) || (s < mn);
`ifdef ADDER_TREE_PIPE_SAT_EN
    if (s > mx) u = mx;
    else if (s < mn) u = mn;
`endif
    e.d = (dw == 32) ? u[31:0] : (u[31:0] & 32'h0000_ffff);
    return e;
  endfunction

  function automatic longint sum9(input logic [287:0] v);
    longint s;
    s = 0;
    for (int i = 0; i < 9; i++) s += longint'($signed(v[i*32 +: 32]));
    return s;
  endfunction

  function automatic logic [287:0] rand_vec();
    logic [287:0] v;
    for (int i = 0; i < 9; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // One clock on the main instance: drive, observe just after the falling edge, keep the scoreboard.
  task automatic step(input logic vld, input logic [287:0] din, input logic ordy,
                      output logic acc, output logic pop,
                      output logic [31:0] gd, output logic go, output exp_t want);
    @(negedge clk);
    m.in_valid  = vld;
    m.Din       = din;
    m.out_ready = ordy;
    #1;
    acc  = vld && m.in_ready;
    pop  = m.out_valid && ordy;
    gd   = m.Dout;
    go   = m.ovf;
    want = '0;
    if (pop) want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    if (acc) exp_q.push_back(model(sum9(din), 32));
  endtask

  task automatic test_reset();
    #12;
    total++; if (m.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0b want=0", m.out_valid); else passes++;
    total++; if (m.Dout !== 32'h0) $display("FAIL rst_dout got=%0h want=0", m.Dout); else passes++;
    total++; if (m.ovf !== 1'b0) $display("FAIL rst_ovf got=%0b want=0", m.ovf); else passes++;
    #10 rst_n = 1'b1;
    @(negedge clk); #1;
    total++; if (m.out_valid !== 1'b0) $display("FAIL rel_out_valid got=%0b want=0", m.out_valid); else passes++;
    total++; if (m.in_ready !== 1'b1) $display("FAIL rel_in_ready got=%0b want=1", m.in_ready); else passes++;
  endtask

  task automatic test_single();
    logic [287:0] v;
    logic acc, pop, go;
    logic [31:0] gd;
    exp_t w;
    for (int i = 0; i < 9; i++) v[i*32 +: 32] = 32'(i + 1);
    step(1'b1, v, 1'b1, acc, pop, gd, go, w);
    total++; if (acc !== 1'b1) $display("FAIL single_accept got=%0b want=1", acc); else passes++;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, '0, 1'b1, acc, pop, gd, go, w);
      total++; if (pop !== (k == 4)) $display("FAIL single_valid cyc=%0d got=%0b want=%0b", k, pop, (k == 4)); else passes++;
      if (k == 4) begin
        total++; if (gd !== 32'd45) $display("FAIL single_dout got=%0d want=45", gd); else passes++;
        total++; if (go !== 1'b0) $display("FAIL single_ovf got=%0b want=0", go); else passes++;
      end
    end
  endtask

  task automatic test_stream();
    logic [287:0] v;
    logic acc, pop, go, vld;
    logic [31:0] gd;
    exp_t w;
    int sent, got, first, last;
    sent = 0; got = 0; first = -1; last = -1;
    v = rand_vec();
    for (int cyc = 0; cyc < 400 && (sent < 100 || exp_q.size() > 0); cyc++) begin
      vld = (sent < 100);
      step(vld, v, 1'b1, acc, pop, gd, go, w);
      if (vld) begin
        total++; if (acc !== 1'b1) $display("FAIL stream_accept n=%0d got=%0b want=1", sent, acc); else passes++;
      end
      if (acc) begin sent++; v = rand_vec(); end
      if (pop) begin
        total++; if (gd !== w.d) $display("FAIL stream_dout n=%0d got=%0h want=%0h", got, gd, w.d); else passes++;
        total++; if (go !== w.o) $display("FAIL stream_ovf n=%0d got=%0b want=%0b", got, go, w.o); else passes++;
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
    end
    total++; if (got !== 100) $display("FAIL stream_count got=%0d want=100", got); else passes++;
    total++; if (last - first !== 99) $display("FAIL stream_rate got=%0d want=99", last - first); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [287:0] v;
    logic acc, pop, go, vld, ordy;
    logic [31:0] gd, held;
    exp_t w;
    int sent, got;
    sent = 0; got = 0; held = '0;
    v = rand_vec();
    for (int cyc = 0; cyc < 200 && (sent < 20 || exp_q.size() > 0); cyc++) begin
      ordy = !(cyc >= 10 && cyc < 16);
      vld  = (sent < 20);
      step(vld, v, ordy, acc, pop, gd, go, w);
      if (!ordy) begin
        if (cyc == 10) held = gd;
        total++; if (acc !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%0b want=0", cyc, m.in_ready); else passes++;
        total++; if (m.out_valid !== 1'b1) $display("FAIL bp_valid cyc=%0d got=%0b want=1", cyc, m.out_valid); else passes++;
        if (cyc > 10) begin
          total++; if (gd !== held) $display("FAIL bp_hold cyc=%0d got=%0h want=%0h", cyc, gd, held); else passes++;
        end
      end
      if (acc) begin sent++; v = rand_vec(); end
      if (pop) begin
        total++; if (gd !== w.d) $display("FAIL bp_dout n=%0d got=%0h want=%0h", got, gd, w.d); else passes++;
        total++; if (go !== w.o) $display("FAIL bp_ovf n=%0d got=%0b want=%0b", got, go, w.o); else passes++;
        got++;
      end
    end
    total++; if (got !== 20) $display("FAIL bp_count got=%0d want=20", got); else passes++;
    total++; if (exp_q.size() !== 0) $display("FAIL bp_leftover got=%0d want=0", exp_q.size()); else passes++;
  endtask

  task automatic test_overflow();
    logic [287:0] vmax, vmin;
    logic acc, pop, go;
    logic [31:0] gd, want_max, want_min;
    exp_t w;
    int sent, got;
    for (int i = 0; i < 9; i++) begin
      vmax[i*32 +: 32] = 32'h7fff_ffff;
      vmin[i*32 +: 32] = 32'h8000_0000;
    end
`ifdef ADDER_TREE_PIPE_SAT_EN
    want_max = 32'h7fff_ffff;
`else
    want_max = 32'h7fff_fff7;
`endif
    want_min = 32'h8000_0000;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
      step(sent < 2, (sent == 0) ? vmax : vmin, 1'b1, acc, pop, gd, go, w);
      if (acc) sent++;
      if (pop) begin
        total++; if (gd !== ((got == 0) ? want_max : want_min))
          $display("FAIL ovf_dout n=%0d got=%0h want=%0h", got, gd, (got == 0) ? want_max : want_min); else passes++;
        total++; if (go !== 1'b1) $display("FAIL ovf_flag n=%0d got=%0b want=1", got, go); else passes++;
        got++;
      end
    end
    total++; if (got !== 2) $display("FAIL ovf_count got=%0d want=2", got); else passes++;
  endtask

  task automatic test_reset_midflight();
    logic acc, pop, go;
    logic [31:0] gd;
    exp_t w;
    for (int n = 0; n < 3; n++) step(1'b1, rand_vec(), 1'b1, acc, pop, gd, go, w);
    for (int n = 0; n < 2; n++) step(1'b0, '0, 1'b1, acc, pop, gd, go, w);
    total++; if (m.out_valid !== 1'b1) $display("FAIL mid_pre_valid got=%0b want=1", m.out_valid); else passes++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (m.out_valid !== 1'b0) $display("FAIL mid_out_valid got=%0b want=0", m.out_valid); else passes++;
    total++; if (m.Dout !== 32'h0) $display("FAIL mid_dout got=%0h want=0", m.Dout); else passes++;
    @(negedge clk);
    #2 rst_n = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 10; k++) begin
      step(1'b0, '0, 1'b1, acc, pop, gd, go, w);
      total++; if (pop !== 1'b0) $display("FAIL mid_stale cyc=%0d got=%0b want=0", k, pop); else passes++;
    end
  endtask

  task automatic test_sweep();
    logic [15:0] a2[2];
    logic [15:0] a8[8];
    logic [15:0] a17[17];
    longint t2, t8, t17;
    exp_t e2, e8, e17;
    for (int rep = 0; rep < 3; rep++) begin
      if (rep == 0) begin
        a2[0] = 16'h7fff; a2[1] = 16'h0001;
        for (int i = 0; i < 8; i++)  a8[i]  = 16'(-(i + 1));
        for (int i = 0; i < 17; i++) a17[i] = 16'(i * 1000 - 8000);
      end else begin
        for (int i = 0; i < 2; i++)  a2[i]  = 16'($urandom_range(0, 65535));
        for (int i = 0; i < 8; i++)  a8[i]  = 16'($urandom_range(0, 65535));
        for (int i = 0; i < 17; i++) a17[i] = 16'($urandom_range(0, 65535));
      end
      t2 = 0; t8 = 0; t17 = 0;
      @(negedge clk);
      for (int i = 0; i < 2; i++)  begin s2.Din[i*16 +: 16]  = a2[i];  t2  += longint'($signed(a2[i]));  end
      for (int i = 0; i < 8; i++)  begin s8.Din[i*16 +: 16]  = a8[i];  t8  += longint'($signed(a8[i]));  end
      for (int i = 0; i < 17; i++) begin s17.Din[i*16 +: 16] = a17[i]; t17 += longint'($signed(a17[i])); end
      e2 = model(t2, 16); e8 = model(t8, 16); e17 = model(t17, 16);
      s2.in_valid = 1'b1; s8.in_valid = 1'b1; s17.in_valid = 1'b1;
      for (int k = 1; k <= 7; k++) begin
        @(negedge clk);
        s2.in_valid = 1'b0; s8.in_valid = 1'b0; s17.in_valid = 1'b0;
        #1;
        total++; if (s2.out_valid !== (k == 1)) $display("FAIL n2_valid rep=%0d cyc=%0d got=%0b", rep, k, s2.out_valid); else passes++;
        total++; if (s8.out_valid !== (k == 3)) $display("FAIL n8_valid rep=%0d cyc=%0d got=%0b", rep, k, s8.out_valid); else passes++;
        total++; if (s17.out_valid !== (k == 5)) $display("FAIL n17_valid rep=%0d cyc=%0d got=%0b", rep, k, s17.out_valid); else passes++;
        if (k == 1) begin
          total++; if ({16'h0, s2.Dout} !== e2.d || s2.ovf !== e2.o)
            $display("FAIL n2_sum rep=%0d got=%0h/%0b want=%0h/%0b", rep, s2.Dout, s2.ovf, e2.d, e2.o); else passes++;
        end
        if (k == 3) begin
          total++; if ({16'h0, s8.Dout} !== e8.d || s8.ovf !== e8.o)
            $display("FAIL n8_sum rep=%0d got=%0h/%0b want=%0h/%0b", rep, s8.Dout, s8.ovf, e8.d, e8.o); else passes++;
        end
        if (k == 5) begin
          total++; if ({16'h0, s17.Dout} !== e17.d || s17.ovf !== e17.o)
            $display("FAIL n17_sum rep=%0d got=%0h/%0b want=%0h/%0b", rep, s17.Dout, s17.ovf, e17.d, e17.o); else passes++;
        end
      end
    end
  endtask

  initial begin
    m.in_valid = 1'b0;   m.Din = '0;   m.out_ready = 1'b0;
    s2.in_valid = 1'b0;  s2.Din = '0;  s2.out_ready = 1'b1;
    s8.in_valid = 1'b0;  s8.Din = '0;  s8.out_ready = 1'b1;
    s17.in_valid = 1'b0; s17.Din = '0; s17.out_ready = 1'b1;
    test_reset();
    test_single();
    test_stream();
    test_back_to_back();
    test_overflow();
    test_reset_midflight();
    test_sweep();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passes, total);
    $fatal(1, "watchdog");
  end

endmodule
